// File: rtl/idct_sched_pkg.sv
// idct_sched_pkg: shared types and default sizes for the IDCT block scheduler.
package idct_sched_pkg;
    typedef enum logic {IDLE, STREAM} sched_state_t;
    typedef logic tag_t;
    localparam int BEATS_PER_BLOCK_DEFAULT = 8;
    localparam int TAG_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/idct_tag_fifo.sv
// idct_tag_fifo: first-word fall-through FIFO of requester tags, simultaneous push/pop allowed.
module idct_tag_fifo
    import idct_sched_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  tag_t din_i,
    input  logic pop_i,
    output tag_t dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    tag_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
endmodule

// File: rtl/idct_block_scheduler.sv
// idct_block_scheduler: shares one IDCT core between luma (0) and chroma (1) requesters, one block per grant.
// Define IDCT_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module idct_block_scheduler
    import idct_sched_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BEATS_PER_BLOCK = BEATS_PER_BLOCK_DEFAULT,
    parameter int TAG_DEPTH       = TAG_DEPTH_DEFAULT
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    output logic                  core_m_tvalid,
    input  logic                  core_m_tready,
    output logic                  core_m_tlast,
    output logic [DATA_WIDTH-1:0] core_m_tdata,
    input  logic                  core_s_tvalid,
    output logic                  core_s_tready,
    input  logic                  core_s_tlast,
    input  logic [DATA_WIDTH-1:0] core_s_tdata,
    output logic                  m0_axis_tvalid,
    input  logic                  m0_axis_tready,
    output logic                  m0_axis_tlast,
    output logic [DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                  m1_axis_tvalid,
    input  logic                  m1_axis_tready,
    output logic                  m1_axis_tlast,
    output logic [DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                  blk_err
);
    localparam int CW = $clog2(BEATS_PER_BLOCK);
    localparam logic [CW-1:0] LAST = CW'(BEATS_PER_BLOCK - 1);
    sched_state_t state_q, state_d;
    tag_t grant_q, grant_d, head, pick;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic blk_err_q, blk_err_d;
    logic streaming, full, empty, push, pop, in_hs, out_hs, req_tlast;
    logic unused_core_tlast;
    assign unused_core_tlast = core_s_tlast;
`ifdef IDCT_SCHED_RR_EN
    tag_t last_grant_q;
    assign pick = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_grant_q : s1_axis_tvalid;
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) last_grant_q <= 1'b1;
        else if (push) last_grant_q <= pick;
    end
`else
    assign pick = ~s0_axis_tvalid;
`endif
    assign streaming      = state_q == STREAM;
    assign core_m_tvalid  = streaming && (grant_q ? s1_axis_tvalid : s0_axis_tvalid);
    assign core_m_tdata   = grant_q ? s1_axis_tdata : s0_axis_tdata;
    assign core_m_tlast   = streaming && in_cnt_q == LAST;
    assign s0_axis_tready = streaming && !grant_q && core_m_tready;
    assign s1_axis_tready = streaming && grant_q && core_m_tready;
    assign req_tlast      = grant_q ? s1_axis_tlast : s0_axis_tlast;
    assign in_hs          = core_m_tvalid && core_m_tready;
    // A same-cycle egress pop frees a slot, so a full FIFO still accepts the grant.
    assign push           = !streaming && (s0_axis_tvalid || s1_axis_tvalid) && (!full || pop);
    assign core_s_tready  = !empty && (head ? m1_axis_tready : m0_axis_tready);
    assign m0_axis_tvalid = !empty && !head && core_s_tvalid;
    assign m1_axis_tvalid = !empty && head && core_s_tvalid;
    assign m0_axis_tlast  = !empty && !head && out_cnt_q == LAST;
    assign m1_axis_tlast  = !empty && head && out_cnt_q == LAST;
    assign m0_axis_tdata  = core_s_tdata;
    assign m1_axis_tdata  = core_s_tdata;
    assign out_hs         = core_s_tvalid && core_s_tready;
    assign pop            = out_hs && out_cnt_q == LAST;
    assign blk_err        = blk_err_q;
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        blk_err_d = in_hs && (req_tlast != core_m_tlast);
        if (push) begin
            state_d = STREAM;
            grant_d = pick;
        end
        if (in_hs) begin
            in_cnt_d = core_m_tlast ? '0 : in_cnt_q + 1'b1;
            state_d  = core_m_tlast ? IDLE : STREAM;
        end
        if (out_hs) out_cnt_d = pop ? '0 : out_cnt_q + 1'b1;
    end
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            blk_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            blk_err_q <= blk_err_d;
        end
    end
    idct_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk_i  (s00_axis_aclk),
        .rst_ni (s00_axis_aresetn),
        .push_i (push),
        .din_i  (pick),
        .pop_i  (pop),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );
endmodule

// File: tb/tb_idct_block_scheduler.sv
// tb_idct_block_scheduler: directed tests with a queue-based scheduler/core model checked every cycle.
module tb_idct_block_scheduler;
    localparam int DW = 64;
    localparam int B = 8;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    logic s0v, s0r, s0l, s1v, s1r, s1l, cmv, cmr, cml, csv, csr, csl;
    logic m0v, m0r, m0l, m1v, m1r, m1l, err;
    logic [DW-1:0] s0d, s1d, cmd, csd, m0d, m1d;

    idct_block_scheduler #(.DATA_WIDTH(DW), .BEATS_PER_BLOCK(B), .TAG_DEPTH(D)) dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rstn),
        .s0_axis_tvalid(s0v), .s0_axis_tready(s0r), .s0_axis_tlast(s0l), .s0_axis_tdata(s0d),
        .s1_axis_tvalid(s1v), .s1_axis_tready(s1r), .s1_axis_tlast(s1l), .s1_axis_tdata(s1d),
        .core_m_tvalid(cmv), .core_m_tready(cmr), .core_m_tlast(cml), .core_m_tdata(cmd),
        .core_s_tvalid(csv), .core_s_tready(csr), .core_s_tlast(csl), .core_s_tdata(csd),
        .m0_axis_tvalid(m0v), .m0_axis_tready(m0r), .m0_axis_tlast(m0l), .m0_axis_tdata(m0d),
        .m1_axis_tvalid(m1v), .m1_axis_tready(m1r), .m1_axis_tlast(m1l), .m1_axis_tdata(m1d),
        .blk_err(err)
    );

    typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
    beat_t rq0[$], rq1[$];
    logic [DW-1:0] core_q[$], rx0[$], rx1[$];
    logic rxl0[$], rxl1[$];
    int order_log[$], egress_log[$];
    int n_chk = 0, n_fail = 0;
    int core_in_n, core_last_n, core_out_n = 0, err_cnt, m1v_cnt;
    bit cin_stall = 0, cout_stall = 0, m0_ok = 1, m1_ok = 1;
    bit m_busy, m_err;
    int m_who, m_beat, m_obeat, m_lastg;
    int m_tags[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_who = 0; m_beat = 0; m_obeat = 0; m_lastg = 1;
        m_tags.delete();
    endtask

    task automatic clear_logs();
        rx0.delete(); rx1.delete(); rxl0.delete(); rxl1.delete();
        order_log.delete(); egress_log.delete();
        core_in_n = 0; core_last_n = 0; err_cnt = 0; m1v_cnt = 0;
    endtask

    task automatic load(int r, logic [DW-1:0] base, logic [7:0] lmask);
        beat_t b;
        for (int i = 0; i < B; i++) begin
            b.d = base + DW'(i);
            b.l = lmask[i];
            if (r == 0) rq0.push_back(b); else rq1.push_back(b);
        end
    endtask

    task automatic drive();
        s0v = rstn && rq0.size() > 0;
        s0d = rq0.size() > 0 ? rq0[0].d : '0;
        s0l = rq0.size() > 0 ? rq0[0].l : 1'b0;
        s1v = rstn && rq1.size() > 0;
        s1d = rq1.size() > 0 ? rq1[0].d : '0;
        s1l = rq1.size() > 0 ? rq1[0].l : 1'b0;
        cmr = !cin_stall;
        csv = rstn && !cout_stall && core_q.size() > 0;
        csd = core_q.size() > 0 ? core_q[0] : '0;
        csl = (core_out_n % B) == B - 1;
        m0r = m0_ok;
        m1r = m1_ok;
    endtask

    task automatic observe();
        bit rv, ecml, has, ecsr, in_hs, out_hs, pop, grant;
        int h, pick;
        rv = m_busy && (m_who == 1 ? s1v : s0v);
        ecml = m_busy && m_beat == B - 1;
        has = m_tags.size() > 0;
        h = has ? m_tags[0] : 0;
        ecsr = has && (h == 1 ? m1r : m0r);
        chk("core_m_tvalid", cmv, rv);
        chk("s0_tready", s0r, m_busy && m_who == 0 && cmr);
        chk("s1_tready", s1r, m_busy && m_who == 1 && cmr);
        chk("core_m_tlast", cml, ecml);
        if (rv) chk("core_m_tdata", cmd, m_who == 1 ? s1d : s0d);
        chk("blk_err", err, m_err);
        chk("core_s_tready", csr, ecsr);
        chk("m0_tvalid", m0v, has && h == 0 && csv);
        chk("m1_tvalid", m1v, has && h == 1 && csv);
        chk("m0_tlast", m0l, has && h == 0 && m_obeat == B - 1);
        chk("m1_tlast", m1l, has && h == 1 && m_obeat == B - 1);
        if (has && csv) chk("m_tdata", h == 1 ? m1d : m0d, csd);
        if (!rstn) model_reset();
        else begin
            in_hs = rv && cmr;
            out_hs = ecsr && csv;
            pop = out_hs && m_obeat == B - 1;
            grant = !m_busy && (s0v || s1v) && (m_tags.size() < D || pop);
`ifdef IDCT_SCHED_RR_EN
            pick = (s0v && s1v) ? 1 - m_lastg : (s1v ? 1 : 0);
`else
            pick = s0v ? 0 : 1;
`endif
            m_err = in_hs && ((m_who == 1 ? s1l : s0l) != ecml);
            if (in_hs) begin
                if (m_beat == B - 1) begin m_beat = 0; m_busy = 0; end
                else m_beat++;
            end
            if (out_hs) begin
                if (pop) begin m_obeat = 0; void'(m_tags.pop_front()); end
                else m_obeat++;
            end
            if (grant) begin m_busy = 1; m_who = pick; m_lastg = pick; m_tags.push_back(pick); end
        end
        if (s0v && s0r) begin if (cml) order_log.push_back(0); void'(rq0.pop_front()); end
        if (s1v && s1r) begin if (cml) order_log.push_back(1); void'(rq1.pop_front()); end
        if (csv && csr) begin void'(core_q.pop_front()); core_out_n++; end
        if (cmv && cmr) begin core_q.push_back(cmd); core_in_n++; if (cml) core_last_n++; end
        if (m0v && m0r) begin rx0.push_back(m0d); rxl0.push_back(m0l); if (m0l) egress_log.push_back(0); end
        if (m1v && m1r) begin rx1.push_back(m1d); rxl1.push_back(m1l); if (m1l) egress_log.push_back(1); end
        if (err) err_cnt++;
        if (m1v) m1v_cnt++;
    endtask

    task automatic cycle();
        drive();
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic run_until_idle(int max);
        int k = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || core_q.size() > 0 || m_busy || m_tags.size() > 0) && k < max) begin
            cycle();
            k++;
        end
        chk("drain_timeout", k < max, 1);
        repeat (2) cycle();
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_s0_tready"}, s0r, 0);
        chk({tag, "_s1_tready"}, s1r, 0);
        chk({tag, "_core_m_tvalid"}, cmv, 0);
        chk({tag, "_core_m_tlast"}, cml, 0);
        chk({tag, "_core_s_tready"}, csr, 0);
        chk({tag, "_m0_tvalid"}, m0v, 0);
        chk({tag, "_m0_tlast"}, m0l, 0);
        chk({tag, "_m1_tvalid"}, m1v, 0);
        chk({tag, "_m1_tlast"}, m1l, 0);
        chk({tag, "_blk_err"}, err, 0);
    endtask

    initial begin
        int exp_ord[8];
        int k;
`ifdef IDCT_SCHED_RR_EN
        exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        model_reset();
        clear_logs();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        // Single luma block through an identity core.
        load(0, 64'h01, 8'h80);
        run_until_idle(100);
        chk("t1_rx0_count", rx0.size(), 8);
        for (int i = 0; i < 8 && i < rx0.size(); i++) begin
            chk("t1_rx0_data", rx0[i], 64'(i + 1));
            chk("t1_rx0_last", rxl0[i], i == 7);
        end
        chk("t1_m1_valid_cycles", m1v_cnt, 0);
        chk("t1_core_beats", core_in_n, 8);
        chk("t1_core_lasts", core_last_n, 1);
        // Contention: both requesters with four blocks each.
        clear_logs();
        for (int b = 0; b < 4; b++) begin
            load(0, 64'h10 + 64'(8 * b), 8'h80);
            load(1, 64'h50 + 64'(8 * b), 8'h80);
        end
        run_until_idle(400);
        chk("t2_grants", order_log.size(), 8);
        chk("t2_egress", egress_log.size(), 8);
        for (int i = 0; i < 8 && i < order_log.size(); i++) chk("t2_grant_order", order_log[i], exp_ord[i]);
        for (int i = 0; i < 8 && i < egress_log.size(); i++) chk("t2_egress_order", egress_log[i], exp_ord[i]);
        chk("t2_rx0_count", rx0.size(), 32);
        chk("t2_rx1_count", rx1.size(), 32);
        for (int i = 0; i < 32 && i < rx0.size(); i++) chk("t2_rx0_data", rx0[i], 64'h10 + 64'(i));
        for (int i = 0; i < 32 && i < rx1.size(); i++) chk("t2_rx1_data", rx1[i], 64'h50 + 64'(i));
        // Early tlast on beat 5 from chroma.
        clear_logs();
        load(1, 64'h70, 8'h90);
        run_until_idle(100);
        chk("t3_err_pulses", err_cnt, 1);
        chk("t3_core_beats", core_in_n, 8);
        chk("t3_core_lasts", core_last_n, 1);
        chk("t3_rx1_count", rx1.size(), 8);
        if (rx1.size() == 8) begin
            chk("t3_rx1_last4", rxl1[4], 0);
            chk("t3_rx1_last7", rxl1[7], 1);
        end
        // Tag FIFO full while the core output is stalled.
        clear_logs();
        cout_stall = 1;
        for (int b = 0; b < 5; b++) load(0, 64'h80 + 64'(8 * b), 8'h80);
        repeat (60) cycle();
        chk("t4_core_beats_stalled", core_in_n, 32);
        chk("t4_grants_stalled", order_log.size(), 4);
        drive();
        #1;
        chk("t4_s0_tready_held", s0r, 0);
        chk("t4_s1_tready_held", s1r, 0);
        @(negedge clk);
        cout_stall = 0;
        run_until_idle(200);
        chk("t4_core_beats", core_in_n, 40);
        chk("t4_rx0_count", rx0.size(), 40);
        for (int i = 0; i < 40 && i < rx0.size(); i++) chk("t4_rx0_data", rx0[i], 64'h80 + 64'(i));
        // Egress backpressure mid-block.
        clear_logs();
        load(0, 64'hA0, 8'h80);
        k = 0;
        while (rx0.size() < 3 && k < 50) begin cycle(); k++; end
        chk("t5_wait", k < 50, 1);
        m0_ok = 0;
        repeat (10) begin
            cycle();
            chk("t5_core_s_tready", csr, 0);
        end
        chk("t5_rx0_frozen", rx0.size(), 3);
        m0_ok = 1;
        run_until_idle(100);
        chk("t5_rx0_count", rx0.size(), 8);
        for (int i = 0; i < 8 && i < rx0.size(); i++) chk("t5_rx0_data", rx0[i], 64'hA0 + 64'(i));
        // Reset at beat 3, then a clean block.
        clear_logs();
        load(0, 64'hC0, 8'h80);
        k = 0;
        while (core_in_n < 3 && k < 50) begin cycle(); k++; end
        chk("t6_wait", k < 50, 1);
        rstn = 1'b0;
        cycle();
        rq0.delete(); rq1.delete(); core_q.delete();
        drive();
        #1;
        chk_all_zero("t6_after_reset");
        @(negedge clk);
        rstn = 1'b1;
        clear_logs();
        load(0, 64'hE0, 8'h80);
        run_until_idle(100);
        chk("t6_rx0_count", rx0.size(), 8);
        for (int i = 0; i < 8 && i < rx0.size(); i++) chk("t6_rx0_data", rx0[i], 64'hE0 + 64'(i));
        chk("t6_rx1_count", rx1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
